small_mem_fifo_ctrl: RTL and testbench

- Valid/ready FIFO controller that sequences a single-port small_mem instance (async read, sync write, one shared address port).
- Instantiates the RAM internally and schedules one RAM operation per cycle, either a write of the input word or a prefetch read into a registered output stage.
- Arbitrates push and pop traffic fairly.
- Used as a shallow elastic buffer between pipeline stages in the CPU and accelerator datapaths.

---
 rtl/small_mem_fifo_ctrl.sv | 91 +++++++++
 tb/tb_small_mem_fifo_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/small_mem_fifo_ctrl.sv
// small_mem_fifo_ctrl: valid/ready FIFO sequencing a single-port small_mem with a registered head word.
// Optional SMALL_MEM_FIFO_BYPASS_EN: when the RAM is empty, an accepted word loads out_data directly.
// Ports: clk, rst_n (async active-low), flush (sync clear);
//        in_valid/in_ready/in_data upstream; out_valid/out_ready/out_data downstream;
//        level = words in RAM + output register (0..DEPTH+1).
module small_mem #(
  parameter int AW = 3,
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] spo
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) if (we) mem[a] <= d;
  assign spo = mem[a];
endmodule

module small_mem_fifo_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   level
);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_a;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  last_rd_q, last_rd_d, out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d, spo;
  logic                  out_free, rd_want, byp, byp_take, wr_gnt, rd_gnt;
  small_mem #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_mem (
    .clk (clk),
    .we  (wr_gnt),
    .a   (ram_a),
    .d   (in_data),
    .spo (spo)
  );
  always_comb begin
    out_free = !out_valid_q || out_ready;
    rd_want  = out_free && cnt_q != '0;
`ifdef SMALL_MEM_FIFO_BYPASS_EN
    byp      = out_free && cnt_q == '0 && !flush;
`else
    byp      = 1'b0;
`endif
    in_ready = !flush && cnt_q != DEPTH && (!rd_want || last_rd_q || byp);
    byp_take = byp && in_valid;
    wr_gnt   = in_valid && in_ready && !byp;
    rd_gnt   = rd_want && !wr_gnt && !flush;
    ram_a    = wr_gnt ? wr_ptr_q : rd_ptr_q;
  end
  always_comb begin
    wr_ptr_d    = flush ? '0 : wr_gnt ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d    = flush ? '0 : rd_gnt ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    cnt_d       = flush ? '0 : wr_gnt ? cnt_q + 1'b1 : rd_gnt ? cnt_q - 1'b1 : cnt_q;
    last_rd_d   = rd_gnt;
    out_valid_d = flush ? 1'b0 : (rd_gnt || byp_take) ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
    out_data_d  = rd_gnt ? spo : byp_take ? in_data : out_data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      last_rd_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      last_rd_q   <= last_rd_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = cnt_q + {{ADDR_WIDTH{1'b0}}, out_valid_q};
endmodule

// File: tb/tb_small_mem_fifo_ctrl.sv
// tb_small_mem_fifo_ctrl: directed checks of small_mem_fifo_ctrl ordering, fairness, full/empty and flush.
module tb_small_mem_fifo_ctrl;
`ifdef SMALL_MEM_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [8:0] out_data;
  logic [3:0] level;
  int         tests = 0;
  int         fails = 0;
  logic       ir_s, ov_s;
  logic [8:0] od_s;
  logic [3:0] lv_s;
  int         held, held_s, acc;
  logic [8:0] got[$];
  small_mem_fifo_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
  );
  always #5 clk = ~clk;
  task automatic cyc(input logic iv, input logic [8:0] d, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    flush = fl;
    #1;
    ir_s = in_ready;
    ov_s = out_valid;
    od_s = out_data;
    lv_s = level;
    held_s = held;
    if (iv && in_ready) begin
      acc++;
      held++;
    end
    if (out_valid && ordy) begin
      got.push_back(out_data);
      held--;
    end
    if (fl) held = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    held = 0;
    acc = 0;
    got.delete();
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 9'h155;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++;
    if (level !== 4'd0) begin fails++; $display("FAIL reset_level got %0d want 0", level); end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    held = 0;
    acc = 0;
    got.delete();
    cyc(0, 9'h0, 0, 0);
    tests++;
    if (lv_s !== 4'd0) begin fails++; $display("FAIL reset_no_write level got %0d want 0", lv_s); end
  endtask
  task automatic test_single();
    do_reset();
    cyc(1, 9'h1A5, 1, 0);
    tests++;
    if (ir_s !== 1'b1 || lv_s !== 4'd0) begin fails++; $display("FAIL single_c0 in_ready %b level %0d want 1 0", ir_s, lv_s); end
    cyc(0, 9'h0, 1, 0);
    tests++;
    if (ov_s !== BYP || lv_s !== 4'd1) begin fails++; $display("FAIL single_c1 out_valid %b level %0d want %b 1", ov_s, lv_s, BYP); end
    if (BYP) begin
      tests++;
      if (od_s !== 9'h1A5) begin fails++; $display("FAIL single_c1_data got %h want 1a5", od_s); end
    end
    cyc(0, 9'h0, 1, 0);
    tests++;
    if (ov_s !== !BYP || lv_s !== (BYP ? 4'd0 : 4'd1)) begin fails++; $display("FAIL single_c2 out_valid %b level %0d want %b %0d", ov_s, lv_s, !BYP, BYP ? 0 : 1); end
    if (!BYP) begin
      tests++;
      if (od_s !== 9'h1A5) begin fails++; $display("FAIL single_c2_data got %h want 1a5", od_s); end
    end
    cyc(0, 9'h0, 1, 0);
    tests++;
    if (ov_s !== 1'b0 || lv_s !== 4'd0) begin fails++; $display("FAIL single_c3 out_valid %b level %0d want 0 0", ov_s, lv_s); end
  endtask
  task automatic test_fill_drain();
    int late = 0;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      cyc(1, 9'(acc), 0, 0);
      if (held_s == 9 && ir_s) late++;
    end
    tests++;
    if (acc != 9) begin fails++; $display("FAIL fill_accepted got %0d want 9", acc); end
    tests++;
    if (lv_s !== 4'd9) begin fails++; $display("FAIL fill_level got %0d want 9", lv_s); end
    tests++;
    if (ir_s !== 1'b0 || late != 0) begin fails++; $display("FAIL fill_in_ready got %b (%0d high while full) want 0", ir_s, late); end
    for (int i = 0; i < 20; i++) cyc(0, 9'h0, 1, 0);
    tests++;
    if (got.size() != 9) begin fails++; $display("FAIL drain_count got %0d want 9", got.size()); end
    for (int i = 0; i < got.size(); i++) if (got[i] !== 9'(i)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL drain_order %0d words out of order", bad); end
    tests++;
    if (lv_s !== 4'd0) begin fails++; $display("FAIL drain_level got %0d want 0", lv_s); end
  endtask
  task automatic test_contention();
    logic       ir [20];
    logic [8:0] exp_q[$];
    int         tog = 0;
    int         bad = 0;
    do_reset();
    for (int i = 0; i < 20 && acc < 5; i++) cyc(1, 9'h0A0 + 9'(acc), 0, 0);
    for (int i = 0; i < 5; i++) exp_q.push_back(9'h0A0 + 9'(i));
    for (int i = 0; i < 20; i++) begin
      cyc(1, 9'h100 + 9'(acc - 5), 1, 0);
      ir[i] = ir_s;
      if (i > 0 && ir[i] === ir[i-1]) tog++;
    end
    tests++;
    if (ir[0] !== 1'b0) begin fails++; $display("FAIL contend_first_grant in_ready %b want 0", ir[0]); end
    tests++;
    if (tog != 0) begin fails++; $display("FAIL contend_alternate %0d non-toggling cycles want 0", tog); end
    tests++;
    if (acc != 15) begin fails++; $display("FAIL contend_accepted got %0d want 15", acc); end
    for (int i = 0; i < 10; i++) exp_q.push_back(9'h100 + 9'(i));
    for (int i = 0; i < 30; i++) cyc(0, 9'h0, 1, 0);
    tests++;
    if (got.size() != 15) begin fails++; $display("FAIL contend_count got %0d want 15", got.size()); end
    for (int i = 0; i < got.size() && i < 15; i++) if (got[i] !== exp_q[i]) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL contend_order %0d words wrong", bad); end
  endtask
  task automatic test_wrap();
    int   w = 0;
    int   bad = 0;
    int   lvbad = 0;
    int   mx = 0;
    logic iv;
    do_reset();
    for (int c = 0; c < 3000 && got.size() < 40; c++) begin
      iv = (w < 40) && ($urandom % 4 != 0);
      cyc(iv, 9'(w), ($urandom % 3) != 0, 0);
      if (iv && ir_s) w++;
      if (int'(lv_s) > mx) mx = int'(lv_s);
      if (int'(lv_s) != held_s) lvbad++;
    end
    tests++;
    if (got.size() != 40) begin fails++; $display("FAIL wrap_count got %0d want 40", got.size()); end
    for (int i = 0; i < got.size(); i++) if (got[i] !== 9'(i)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL wrap_order %0d words wrong", bad); end
    tests++;
    if (mx > 9) begin fails++; $display("FAIL wrap_max_level got %0d want <=9", mx); end
    tests++;
    if (lvbad != 0) begin fails++; $display("FAIL wrap_level_track %0d cycles disagree with held count", lvbad); end
  endtask
  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 20 && acc < 5; i++) cyc(1, 9'h050 + 9'(acc), 0, 0);
    cyc(0, 9'h0, 0, 0);
    tests++;
    if (lv_s !== 4'd5) begin fails++; $display("FAIL flush_pre_level got %0d want 5", lv_s); end
    cyc(1, 9'h1FF, 0, 1);
    tests++;
    if (ir_s !== 1'b0) begin fails++; $display("FAIL flush_in_ready got %b want 0", ir_s); end
    cyc(0, 9'h0, 0, 0);
    tests++;
    if (lv_s !== 4'd0 || ov_s !== 1'b0) begin fails++; $display("FAIL flush_clear level %0d out_valid %b want 0 0", lv_s, ov_s); end
    got.delete();
    cyc(1, 9'h0F0, 1, 0);
    tests++;
    if (ir_s !== 1'b1) begin fails++; $display("FAIL flush_repush in_ready got %b want 1", ir_s); end
    for (int i = 0; i < 6; i++) cyc(0, 9'h0, 1, 0);
    tests++;
    if (got.size() != 1 || got[0] !== 9'h0F0) begin fails++; $display("FAIL flush_first_out got %0d words head %h want 1 word 0f0", got.size(), got.size() > 0 ? got[0] : 9'h0); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_contention();
    test_wrap();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
